// File: rtl/uart_time_cmd_parser_pkg.sv
// Shared types and constants for the UART time-set command parser.
// The optional alarm command is enabled with `define UART_CMD_ALARM_EN.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    H_T,
    H_U,
    COL1,
    M_T,
    M_U,
    COL2,
    S_T,
    S_U,
    TERM
  } state_e;

  localparam logic [7:0] CMD_TIME  = 8'h54;
  localparam logic [7:0] CMD_ALARM = 8'h41;
  localparam logic [7:0] COLON     = 8'h3A;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] DIGIT0    = 8'h30;
  localparam logic [7:0] DIGIT9    = 8'h39;

  localparam logic [1:0] ERR_SYNTAX  = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= DIGIT0) && (b <= DIGIT9);
  endfunction

  function automatic logic [3:0] digit_val(input logic [7:0] b);
    logic [7:0] d;
    d = b - DIGIT0;
    return d[3:0];
  endfunction

  // Two BCD-like digits to a 7-bit binary value (max 99).
  function automatic logic [6:0] two_digit(input logic [3:0] tens, input logic [3:0] units);
    return (7'(tens) * 7'd10) + 7'(units);
  endfunction

endpackage

// File: rtl/uart_time_cmd_parser_if.sv
// Byte-stream input and time/error outputs of the command parser.
// Alarm signals exist only when UART_CMD_ALARM_EN is defined.
interface uart_time_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       set_valid;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       err;
  logic [1:0] err_code;
  logic       busy;
`ifdef UART_CMD_ALARM_EN
  logic       alarm_valid;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;

  modport master (
    output rx_data, rx_ready,
    input  set_valid, set_hour, set_min, set_sec, err, err_code, busy,
           alarm_valid, alarm_hour, alarm_min
  );
  modport slave (
    input  rx_data, rx_ready,
    output set_valid, set_hour, set_min, set_sec, err, err_code, busy,
           alarm_valid, alarm_hour, alarm_min
  );
`else
  modport master (
    output rx_data, rx_ready,
    input  set_valid, set_hour, set_min, set_sec, err, err_code, busy
  );
  modport slave (
    input  rx_data, rx_ready,
    output set_valid, set_hour, set_min, set_sec, err, err_code, busy
  );
`endif
endinterface

// File: rtl/uart_time_cmd_parser_timer.sv
// Inter-byte timeout counter: counts while enabled, cleared by each byte,
// and pulses expired on the cycle the count would reach TIMEOUT_CYCLES-1.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  // Firing on the increment into TIMEOUT_CYCLES-1 lets the registered err
  // land exactly TIMEOUT_CYCLES cycles after the last byte; a byte wins.
  always_comb begin
    expired = enable && !clear && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_time_cmd_parser.sv
// ASCII "THH:MM:SS<CR|LF>" time-set parser with registered set/err strobes.
// Define UART_CMD_ALARM_EN to add the "AHH:MM<CR|LF>" alarm command.
module uart_time_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ
) (
  input logic                   clk,
  input logic                   reset_n,
  uart_time_cmd_parser_if.slave bus
);

  state_e     state_q;
  logic [3:0] ht_q, hu_q, mt_q, mu_q, st_q, su_q;
  logic       set_valid_q;
  logic       err_q;
  logic [1:0] err_code_q;
  logic [4:0] set_hour_q;
  logic [5:0] set_min_q;
  logic [5:0] set_sec_q;

  logic [7:0] rx_byte;
  logic [3:0] rx_digit;
  logic [6:0] hour_v, min_v, sec_v;
  logic       hm_ok, time_ok;
  logic       byte_ok;
  logic       alarm_path;
  logic       expired;

`ifdef UART_CMD_ALARM_EN
  logic       alarm_q;
  logic       alarm_valid_q;
  logic [4:0] alarm_hour_q;
  logic [5:0] alarm_min_q;

  assign alarm_path      = alarm_q;
  assign bus.alarm_valid = alarm_valid_q;
  assign bus.alarm_hour  = alarm_hour_q;
  assign bus.alarm_min   = alarm_min_q;
`else
  assign alarm_path = 1'b0;
`endif

  always_comb begin
    rx_byte  = bus.rx_data;
    rx_digit = digit_val(rx_byte);
    hour_v   = two_digit(ht_q, hu_q);
    min_v    = two_digit(mt_q, mu_q);
    sec_v    = two_digit(st_q, su_q);
    hm_ok    = (hour_v <= 7'd23) && (min_v <= 7'd59);
    time_ok  = hm_ok && (sec_v <= 7'd59);
    byte_ok  = 1'b1;
    case (state_q)
      H_T, H_U, M_T, M_U, S_T, S_U: byte_ok = is_digit(rx_byte);
      COL1, COL2:                   byte_ok = (rx_byte == COLON);
      TERM:                         byte_ok = (rx_byte == CR) || (rx_byte == LF);
      default:                      byte_ok = 1'b1;
    endcase
  end

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.rx_ready),
    .enable  (state_q != IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ht_q        <= '0;
      hu_q        <= '0;
      mt_q        <= '0;
      mu_q        <= '0;
      st_q        <= '0;
      su_q        <= '0;
      set_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      set_hour_q  <= '0;
      set_min_q   <= '0;
      set_sec_q   <= '0;
`ifdef UART_CMD_ALARM_EN
      alarm_q       <= 1'b0;
      alarm_valid_q <= 1'b0;
      alarm_hour_q  <= '0;
      alarm_min_q   <= '0;
`endif
    end else begin
      set_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef UART_CMD_ALARM_EN
      alarm_valid_q <= 1'b0;
`endif
      if (bus.rx_ready) begin
        if (!byte_ok) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_SYNTAX;
          state_q    <= IDLE;
        end else begin
          case (state_q)
            IDLE: begin
              if (rx_byte == CMD_TIME) begin
                state_q <= H_T;
`ifdef UART_CMD_ALARM_EN
                alarm_q <= 1'b0;
              end else if (rx_byte == CMD_ALARM) begin
                state_q <= H_T;
                alarm_q <= 1'b1;
`endif
              end
            end
            H_T:  begin ht_q <= rx_digit; state_q <= H_U;  end
            H_U:  begin hu_q <= rx_digit; state_q <= COL1; end
            COL1: state_q <= M_T;
            M_T:  begin mt_q <= rx_digit; state_q <= M_U;  end
            M_U:  begin mu_q <= rx_digit; state_q <= alarm_path ? TERM : COL2; end
            COL2: state_q <= S_T;
            S_T:  begin st_q <= rx_digit; state_q <= S_U;  end
            S_U:  begin su_q <= rx_digit; state_q <= TERM; end
            TERM: begin
              state_q <= IDLE;
`ifdef UART_CMD_ALARM_EN
              if (alarm_q) begin
                if (hm_ok) begin
                  alarm_valid_q <= 1'b1;
                  alarm_hour_q  <= hour_v[4:0];
                  alarm_min_q   <= min_v[5:0];
                end else begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_RANGE;
                end
              end else
`endif
              if (time_ok) begin
                set_valid_q <= 1'b1;
                set_hour_q  <= hour_v[4:0];
                set_min_q   <= min_v[5:0];
                set_sec_q   <= sec_v[5:0];
              end else begin
                err_q      <= 1'b1;
                err_code_q <= ERR_RANGE;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end else if (expired) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state_q    <= IDLE;
      end
    end
  end

  assign bus.set_valid = set_valid_q;
  assign bus.set_hour  = set_hour_q;
  assign bus.set_min   = set_min_q;
  assign bus.set_sec   = set_sec_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_time_cmd_parser.sv
// Directed, table-driven bench for uart_time_cmd_parser (TIMEOUT_CYCLES=50).
// Alarm checks are compiled in when UART_CMD_ALARM_EN is defined.
module tb_uart_time_cmd_parser;

  localparam int unsigned TMO = 50;
  localparam int unsigned NV  = 12;

  logic clk;
  logic reset_n;
  uart_time_cmd_parser_if bus ();

  uart_time_cmd_parser #(
    .CLK_FREQ       (100000000),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8*14-1:0] cmd;
    int unsigned     len;
    int unsigned     gap;
    logic            exp_sv;
    logic            exp_err;
    logic [1:0]      exp_code;
    logic [4:0]      h;
    logic [5:0]      m;
    logic [5:0]      s;
  } vec_t;

  vec_t vecs [NV];

  int tests;
  int fails;
  int unsigned sv_cnt;
  int unsigned err_cnt;
  logic last_sv;
  logic last_err;
`ifdef UART_CMD_ALARM_EN
  int unsigned al_cnt;
  logic last_al;
`endif

  always @(negedge clk) begin
    if (bus.set_valid) sv_cnt++;
    if (bus.err) err_cnt++;
`ifdef UART_CMD_ALARM_EN
    if (bus.alarm_valid) al_cnt++;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bytes go out MSB-first from the packed string; gap=0 keeps rx_ready high.
  task automatic send_str(input logic [8*14-1:0] s, input int unsigned len, input int unsigned gap);
    logic [8*14-1:0] tmp;
    for (int unsigned i = 0; i < len; i++) begin
      tmp = s >> (8 * (len - 1 - i));
      bus.rx_data  = tmp[7:0];
      bus.rx_ready = 1'b1;
      @(negedge clk);
      last_sv  = bus.set_valid;
      last_err = bus.err;
`ifdef UART_CMD_ALARM_EN
      last_al  = bus.alarm_valid;
`endif
      if (gap != 0 || i == len - 1) begin
        bus.rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sv0, e0;
`ifdef UART_CMD_ALARM_EN
    int unsigned a0;
`endif
    tests = 0; fails = 0; sv_cnt = 0; err_cnt = 0;
    last_sv = 1'b0; last_err = 1'b0;
`ifdef UART_CMD_ALARM_EN
    al_cnt = 0; last_al = 1'b0;
`endif

    //                cmd                      len gap sv err code  h   m   s
    vecs[0]  = '{"T12:34:56\015",              10, 20, 1, 0, 2'd0, 12, 34, 56};
    vecs[1]  = '{"T24:00:00\012",              10,  3, 0, 1, 2'd2, 12, 34, 56};
    vecs[2]  = '{"T1x",                          3,  2, 0, 1, 2'd1, 12, 34, 56};
    vecs[3]  = '{"T00:00:00\015",              10,  0, 1, 0, 2'd0,  0,  0,  0};
    vecs[4]  = '{"\015",                         1,  0, 0, 0, 2'd0,  0,  0,  0};
    vecs[5]  = '{"T23:59:59\012",              10,  1, 1, 0, 2'd0, 23, 59, 59};
    vecs[6]  = '{"T12:60:00\015",              10,  0, 0, 1, 2'd2, 23, 59, 59};
    vecs[7]  = '{"T01:02:03X",                 10,  2, 0, 1, 2'd1, 23, 59, 59};
    vecs[8]  = '{"T12:34:5\015",                9,  0, 0, 1, 2'd1, 23, 59, 59};
    vecs[9]  = '{"A07:45\015",                  7,  1, 0, 0, 2'd0, 23, 59, 59};
    vecs[10] = '{"T1:",                          3,  0, 0, 1, 2'd1, 23, 59, 59};
    vecs[11] = '{"xyzT05:06:07\015",           13,  1, 1, 0, 2'd0,  5,  6,  7};

    reset_n = 1'b0;
    bus.rx_data = '0;
    bus.rx_ready = 1'b0;
    #1;
    check("rst_set_valid", 32'(bus.set_valid), 32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    check("rst_err_code",  32'(bus.err_code),  32'd0);
    check("rst_set_hour",  32'(bus.set_hour),  32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int unsigned k = 0; k < NV; k++) begin
      sv0 = sv_cnt;
      e0  = err_cnt;
      send_str(vecs[k].cmd, vecs[k].len, vecs[k].gap);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_sv_strobe", k),  32'(last_sv),  32'(vecs[k].exp_sv));
      check($sformatf("v%0d_err_strobe", k), 32'(last_err), 32'(vecs[k].exp_err));
      check($sformatf("v%0d_sv_count", k),   sv_cnt - sv0,  32'(vecs[k].exp_sv));
      check($sformatf("v%0d_err_count", k),  err_cnt - e0,  32'(vecs[k].exp_err));
      if (vecs[k].exp_err)
        check($sformatf("v%0d_err_code", k), 32'(bus.err_code), 32'(vecs[k].exp_code));
      check($sformatf("v%0d_hour", k), 32'(bus.set_hour), 32'(vecs[k].h));
      check($sformatf("v%0d_min", k),  32'(bus.set_min),  32'(vecs[k].m));
      check($sformatf("v%0d_sec", k),  32'(bus.set_sec),  32'(vecs[k].s));
      check($sformatf("v%0d_busy", k), 32'(bus.busy),     32'd0);
    end

`ifdef UART_CMD_ALARM_EN
    sv0 = sv_cnt; e0 = err_cnt; a0 = al_cnt;
    send_str("A07:45\015", 7, 1);
    repeat (2) @(negedge clk);
    check("al_ok_strobe",   32'(last_al),  32'd1);
    check("al_ok_err",      32'(last_err), 32'd0);
    check("al_ok_count",    al_cnt - a0,   32'd1);
    check("al_ok_hour",     32'(bus.alarm_hour), 32'd7);
    check("al_ok_min",      32'(bus.alarm_min),  32'd45);
    check("al_ok_no_set",   sv_cnt - sv0,  32'd0);
    a0 = al_cnt;
    send_str("A07:60\015", 7, 0);
    repeat (2) @(negedge clk);
    check("al_rng_err",     32'(last_err),     32'd1);
    check("al_rng_code",    32'(bus.err_code), 32'd2);
    check("al_rng_count",   al_cnt - a0,       32'd0);
    check("al_rng_hold",    32'(bus.alarm_min), 32'd45);
    check("al_err_total",   err_cnt - e0,      32'd1);
`endif

    // Stall after "T12": err appears exactly TMO cycles after the '2' strobe.
    e0 = err_cnt;
    send_str("T12", 3, 0);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_not_early", 32'(bus.err), 32'd0);
    check("tmo_busy_wait", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("tmo_err",       32'(bus.err),      32'd1);
    check("tmo_code",      32'(bus.err_code), 32'd3);
    @(negedge clk);
    check("tmo_busy_drop", 32'(bus.busy), 32'd0);
    check("tmo_err_count", err_cnt - e0,  32'd1);

    // A byte on the would-expire cycle is processed instead.
    repeat (2) @(negedge clk);
    e0 = err_cnt; sv0 = sv_cnt;
    send_str("T12", 3, 0);
    repeat (TMO - 2) @(negedge clk);
    send_str(":", 1, 0);
    check("race_no_err",   32'(last_err), 32'd0);
    send_str("34:56\015", 6, 1);
    repeat (2) @(negedge clk);
    check("race_err_count", err_cnt - e0, 32'd0);
    check("race_sv_count",  sv_cnt - sv0, 32'd1);
    check("race_min",       32'(bus.set_min), 32'd34);

    // Reset mid-command.
    send_str("T12:3", 5, 1);
    check("mid_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_hour",  32'(bus.set_hour),  32'd0);
    check("mid_rst_min",   32'(bus.set_min),   32'd0);
    check("mid_rst_sec",   32'(bus.set_sec),   32'd0);
    check("mid_rst_code",  32'(bus.err_code),  32'd0);
    check("mid_rst_busy",  32'(bus.busy),      32'd0);
    check("mid_rst_err",   32'(bus.err),       32'd0);
    check("mid_rst_sv",    32'(bus.set_valid), 32'd0);
`ifdef UART_CMD_ALARM_EN
    check("mid_rst_alarm", 32'(bus.alarm_hour), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    e0 = err_cnt; sv0 = sv_cnt;
    send_str("\015", 1, 2);
    check("post_cr_ignored", (err_cnt - e0) + (sv_cnt - sv0), 32'd0);
    check("post_cr_busy",    32'(bus.busy), 32'd0);
    send_str("T01:02:03\015", 10, 1);
    check("post_sv",   32'(last_sv), 32'd1);
    check("post_hour", 32'(bus.set_hour), 32'd1);
    check("post_min",  32'(bus.set_min),  32'd2);
    check("post_sec",  32'(bus.set_sec),  32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
